// File: rtl/fifo_drain_checker_pkg.sv
// Shared definitions for the async FIFO read-side drain checker.
// Also used by the write-side producer.
package fifo_drain_checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RD    = 2'd1,
        ST_CAP   = 2'd2,
        ST_PAUSE = 2'd3
    } state_t;

    localparam int RD_LATENCY   = 1;
    localparam int PATTERN_STEP = 1;

endpackage

// File: rtl/fifo_drain_checker_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 inc,
    input  logic                 clr,
    output logic [CNT_WIDTH-1:0] value
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value <= '0;
        end else if (clr) begin
            value <= '0;
        end else if (inc && (value != '1)) begin
            value <= value + CNT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/fifo_drain_checker.sv
// Read-domain consumer for the async FIFO.
// Drains words, checks the incrementing pattern, and keeps saturating statistics.
module fifo_drain_checker
    import fifo_drain_checker_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CNT_WIDTH    = 16,
    parameter int PAUSE_CYCLES = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  clear,
    input  logic                  empty,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic [CNT_WIDTH-1:0]  word_count,
    output logic [CNT_WIDTH-1:0]  err_count,
    output logic                  err_flag,
    output logic [DATA_WIDTH-1:0] first_err_data,
    output logic                  busy
);

    localparam int PCW = (PAUSE_CYCLES > 1) ? $clog2(PAUSE_CYCLES) : 1;
    localparam logic [PCW-1:0] PAUSE_LAST = PCW'((PAUSE_CYCLES > 0) ? PAUSE_CYCLES - 1 : 0);

    state_t                state;
    logic [DATA_WIDTH-1:0] expected;
    logic [PCW-1:0]        pause_cnt;
    logic                  cap_cycle;
    logic                  mismatch;
    logic                  count_word;
    logic                  count_err;

    function automatic logic [DATA_WIDTH-1:0] next_expected(input logic [DATA_WIDTH-1:0] d);
        return d + DATA_WIDTH'(PATTERN_STEP);
    endfunction

    assign cap_cycle  = (state == ST_CAP);
    assign mismatch   = (rd_data != expected);
    assign count_word = cap_cycle && !clear;
    assign count_err  = count_word && mismatch;

    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_word_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (count_word),
        .clr   (clear),
        .value (word_count)
    );

    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_err_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (count_err),
        .clr   (clear),
        .value (err_count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= ST_IDLE;
            rd_en          <= 1'b0;
            rx_data        <= '0;
            rx_valid       <= 1'b0;
            expected       <= '0;
            pause_cnt      <= '0;
            err_flag       <= 1'b0;
            first_err_data <= '0;
            busy           <= 1'b0;
        end else begin
            rd_en    <= 1'b0;
            rx_valid <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (enable && !empty) begin
                        rd_en <= 1'b1;
                        busy  <= 1'b1;
                        state <= ST_RD;
                    end
                end
                ST_RD: begin
                    state <= ST_CAP;
                end
                ST_CAP: begin
                    rx_data  <= rd_data;
                    rx_valid <= 1'b1;
                    if (PAUSE_CYCLES > 0) begin
                        pause_cnt <= '0;
                        state     <= ST_PAUSE;
                    end else begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                ST_PAUSE: begin
                    if (pause_cnt == PAUSE_LAST) begin
                        pause_cnt <= '0;
                        busy      <= 1'b0;
                        state     <= ST_IDLE;
                    end else begin
                        pause_cnt <= pause_cnt + PCW'(1);
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase

            // On a match rd_data equals expected, so resync and advance share one path.
            if (clear) begin
                expected       <= '0;
                err_flag       <= 1'b0;
                first_err_data <= '0;
            end else if (cap_cycle) begin
                expected <= next_expected(rd_data);
                if (mismatch && !err_flag) begin
                    err_flag       <= 1'b1;
                    first_err_data <= rd_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_fifo_drain_checker.sv
// Directed bench for fifo_drain_checker with a FIFO model and rx scoreboard.
// A second instance covers the pause throttle and counter saturation.
module tb_fifo_drain_checker;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Main instance: no pause, default widths
    logic       enable = 1'b0, clear = 1'b0, empty;
    logic [7:0] rd_data = 8'h00;
    logic       rd_en, rx_valid, err_flag, busy;
    logic [7:0] rx_data, first_err_data;
    logic [15:0] word_count, err_count;

    fifo_drain_checker #(.DATA_WIDTH(8), .CNT_WIDTH(16), .PAUSE_CYCLES(0)) dut (
        .clk(clk), .reset(reset), .enable(enable), .clear(clear), .empty(empty),
        .rd_data(rd_data), .rd_en(rd_en), .rx_data(rx_data), .rx_valid(rx_valid),
        .word_count(word_count), .err_count(err_count), .err_flag(err_flag),
        .first_err_data(first_err_data), .busy(busy)
    );

    // Pause instance with 2-bit counters
    logic       enable_p = 1'b0, clear_p = 1'b0, empty_p;
    logic [7:0] rd_data_p = 8'h00;
    logic       rd_en_p, rx_valid_p, err_flag_p, busy_p;
    logic [7:0] rx_data_p, first_err_data_p;
    logic [1:0] word_count_p, err_count_p;

    fifo_drain_checker #(.DATA_WIDTH(8), .CNT_WIDTH(2), .PAUSE_CYCLES(4)) dut_p (
        .clk(clk), .reset(reset), .enable(enable_p), .clear(clear_p), .empty(empty_p),
        .rd_data(rd_data_p), .rd_en(rd_en_p), .rx_data(rx_data_p), .rx_valid(rx_valid_p),
        .word_count(word_count_p), .err_count(err_count_p), .err_flag(err_flag_p),
        .first_err_data(first_err_data_p), .busy(busy_p)
    );

    // FIFO models: one-cycle read latency
    logic [7:0] mem   [0:1023];
    logic [7:0] mem_p [0:63];
    int wr_ptr = 0, rd_ptr = 0, wr_ptr_p = 0, rd_ptr_p = 0;
    int underflow = 0;
    assign empty   = (wr_ptr == rd_ptr);
    assign empty_p = (wr_ptr_p == rd_ptr_p);

    always @(posedge clk) begin
        if (rd_en) begin
            if (wr_ptr == rd_ptr) underflow <= underflow + 1;
            rd_data <= mem[rd_ptr % 1024];
            rd_ptr  <= rd_ptr + 1;
        end
        if (rd_en_p) begin
            if (wr_ptr_p == rd_ptr_p) underflow <= underflow + 1;
            rd_data_p <= mem_p[rd_ptr_p % 64];
            rd_ptr_p  <= rd_ptr_p + 1;
        end
    end

    logic [7:0] exp_q [$];
    int rd_times [$];
    int rd_times_p [$];
    int last_rd = 0;
    int rx_cnt_p = 0;
    logic [7:0] last_rx_p = 8'h00;
    logic prev_rd = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (rd_en) begin
                chk("rd_en_back_to_back", {31'd0, prev_rd}, 32'd0);
                rd_times.push_back(cyc);
                last_rd = cyc;
            end
            if (rx_valid) begin
                chk("rx_latency", cyc - last_rd, 32'd2);
                chk("sb_has_entry", {31'd0, exp_q.size() > 0}, 32'd1);
                if (exp_q.size() > 0) chk("rx_data", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
            end
            if (rd_en_p) rd_times_p.push_back(cyc);
            if (rx_valid_p) begin
                rx_cnt_p++;
                last_rx_p = rx_data_p;
            end
        end
        prev_rd = rd_en;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        mem[wr_ptr % 1024] = d;
        wr_ptr++;
        exp_q.push_back(d);
    endtask

    task automatic push_lost(input logic [7:0] d);
        mem[wr_ptr % 1024] = d;
        wr_ptr++;
    endtask

    task automatic push_p(input logic [7:0] d);
        mem_p[wr_ptr_p % 64] = d;
        wr_ptr_p++;
    endtask

    task automatic wait_words(input int n, input int budget);
        for (int i = 0; i < budget && int'(word_count) != n; i++) tick(1);
        chk("word_count_reached", {16'd0, word_count}, n);
    endtask

    task automatic wait_rd(input int budget);
        for (int i = 0; i < budget && !rd_en; i++) tick(1);
        chk("wait_rd_en", {31'd0, rd_en}, 32'd1);
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
    endtask

    initial begin
        int n;
        tick(3);
        chk("rst_rd_en", {31'd0, rd_en}, 0);
        chk("rst_rx_valid", {31'd0, rx_valid}, 0);
        chk("rst_rx_data", {24'd0, rx_data}, 0);
        chk("rst_word_count", {16'd0, word_count}, 0);
        chk("rst_err_count", {16'd0, err_count}, 0);
        chk("rst_err_flag", {31'd0, err_flag}, 0);
        chk("rst_first_err", {24'd0, first_err_data}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        reset = 1'b0;

        // Enabled but empty: no reads
        enable = 1'b1;
        tick(20);
        chk("empty_no_rd", rd_times.size(), 0);
        chk("empty_busy", {31'd0, busy}, 0);
        chk("empty_word_count", {16'd0, word_count}, 0);

        // Preloaded 0..4
        enable = 1'b0;
        rd_times.delete();
        for (int i = 0; i < 5; i++) push(8'(i));
        enable = 1'b1;
        wait_words(5, 100);
        tick(3);
        chk("burst_err_count", {16'd0, err_count}, 0);
        chk("burst_rd_pulses", rd_times.size(), 5);
        for (int i = 0; i < 4 && i + 1 < rd_times.size(); i++)
            chk("burst_rd_spacing", rd_times[i+1] - rd_times[i], 3);
        chk("burst_sb_drained", exp_q.size(), 0);
        chk("burst_idle_busy", {31'd0, busy}, 0);

        // One bad word resyncs
        pulse_clear();
        chk("clear_word_count", {16'd0, word_count}, 0);
        push(8'h00); push(8'h01); push(8'h07); push(8'h08);
        wait_words(4, 100);
        tick(3);
        chk("mis_err_count", {16'd0, err_count}, 1);
        chk("mis_err_flag", {31'd0, err_flag}, 1);
        chk("mis_first_err", {24'd0, first_err_data}, 32'h07);

        // 258 words across the 0xFF -> 0x00 wrap
        pulse_clear();
        chk("clear_err_flag", {31'd0, err_flag}, 0);
        for (int i = 0; i < 258; i++) push(8'(i));
        wait_words(258, 1000);
        tick(3);
        chk("wrap_err_count", {16'd0, err_count}, 0);
        chk("wrap_err_flag", {31'd0, err_flag}, 0);
        chk("wrap_sb_drained", exp_q.size(), 0);

        // Pause instance: two queued words 7 cycles apart
        push_p(8'h00); push_p(8'h01);
        rd_times_p.delete();
        enable_p = 1'b1;
        for (int i = 0; i < 100 && word_count_p != 2'd2; i++) tick(1);
        tick(8);
        chk("pause_word_count", {30'd0, word_count_p}, 2);
        chk("pause_rd_pulses", rd_times_p.size(), 2);
        if (rd_times_p.size() == 2) chk("pause_rd_spacing", rd_times_p[1] - rd_times_p[0], 7);

        // Enable dropped while in RD
        enable_p = 1'b0;
        push_p(8'h02); push_p(8'h03);
        rd_times_p.delete();
        enable_p = 1'b1;
        for (int i = 0; i < 50 && !rd_en_p; i++) tick(1);
        chk("pause_wait_rd", {31'd0, rd_en_p}, 1);
        enable_p = 1'b0;
        tick(30);
        chk("drop_word_count", {30'd0, word_count_p}, 3);
        chk("drop_last_rx", {24'd0, last_rx_p}, 32'h02);
        chk("drop_rd_pulses", rd_times_p.size(), 1);
        chk("drop_busy", {31'd0, busy_p}, 0);

        // Saturation at 2'b11
        n = rx_cnt_p;
        push_p(8'h04);
        enable_p = 1'b1;
        for (int i = 0; i < 100 && rx_cnt_p < n + 2; i++) tick(1);
        tick(8);
        chk("sat_rx_count", rx_cnt_p, n + 2);
        chk("sat_word_count", {30'd0, word_count_p}, 3);
        chk("sat_last_rx", {24'd0, last_rx_p}, 32'h04);
        chk("sat_err_count", {30'd0, err_count_p}, 0);

        // Reset while in CAP: word lost, counters zero at once
        push_lost(8'h02);
        wait_rd(20);
        tick(1);
        chk("cap_busy", {31'd0, busy}, 1);
        reset = 1'b1;
        #1;
        chk("arst_rd_en", {31'd0, rd_en}, 0);
        chk("arst_word_count", {16'd0, word_count}, 0);
        chk("arst_busy", {31'd0, busy}, 0);
        chk("arst_rx_valid", {31'd0, rx_valid}, 0);
        tick(2);
        reset = 1'b0;
        tick(5);
        chk("arst_still_zero", {16'd0, word_count}, 0);

        // clear during CAP
        push(8'h00);
        wait_words(1, 50);
        tick(3);
        push(8'h05);
        wait_rd(20);
        tick(1);
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        chk("clr_cap_rx_valid", {31'd0, rx_valid}, 1);
        chk("clr_cap_rx_data", {24'd0, rx_data}, 32'h05);
        chk("clr_cap_word_count", {16'd0, word_count}, 0);
        chk("clr_cap_err_count", {16'd0, err_count}, 0);
        chk("clr_cap_err_flag", {31'd0, err_flag}, 0);
        tick(2);
        push(8'h00);
        wait_words(1, 50);
        tick(3);
        chk("clr_expected_zero", {16'd0, err_count}, 0);

        chk("fifo_underflow", underflow, 0);
        chk("final_sb_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
